// File: rtl/led_chaser_pkg.sv
// Shared types and constants for the LED chaser: mode codes, bounce
// direction encoding and the pattern each mode starts from.
package led_chaser_pkg;

  localparam int MODE_W = 2;
  localparam int LED_W  = 8;

  typedef enum logic [MODE_W-1:0] {
    SHIFT_L = 2'd0,
    SHIFT_R = 2'd1,
    BOUNCE  = 2'd2,
    BLINK   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [LED_W-1:0] INIT_SHIFT_L = 8'h01;
  localparam logic [LED_W-1:0] INIT_SHIFT_R = 8'h80;
  localparam logic [LED_W-1:0] INIT_BOUNCE  = 8'h01;
  localparam logic [LED_W-1:0] INIT_BLINK   = 8'h0F;

  localparam logic [LED_W-1:0] LED_LSB = 8'h01;
  localparam logic [LED_W-1:0] LED_MSB = 8'h80;

  function automatic logic [LED_W-1:0] initial_pattern(input mode_t m);
    logic [LED_W-1:0] p;
    case (m)
      SHIFT_L: p = INIT_SHIFT_L;
      SHIFT_R: p = INIT_SHIFT_R;
      BOUNCE:  p = INIT_BOUNCE;
      default: p = INIT_BLINK;
    endcase
    return p;
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      SHIFT_L: n = SHIFT_R;
      SHIFT_R: n = BOUNCE;
      BOUNCE:  n = BLINK;
      default: n = SHIFT_L;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_chaser_edge_rise.sv
// Rising-edge detector; the history register tracks the input even in reset
// so a level held high across reset release never looks like a new edge.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    prev <= in;
  end

  always_comb begin
    pulse = in & ~prev & ~rst;
  end

endmodule

// File: rtl/led_chaser.sv
// LED chaser: steps an 8-bit pattern on tick rising edges according to the
// current mode; the mode button cycles modes and reloads the start pattern.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              mode_btn,
  input  logic              run,
  output logic [WIDTH-1:0]  leds,
  output logic [MODE_W-1:0] mode
);

  logic step;
  logic mode_evt;

  mode_t            mode_q, mode_n;
  dir_t             dir_q, dir_n;
  logic [LED_W-1:0] led_q, led_n;

  edge_rise u_tick_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (tick_in),
    .pulse (step)
  );

  edge_rise u_mode_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (mode_btn),
    .pulse (mode_evt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= SHIFT_L;
      dir_q  <= DIR_LEFT;
      led_q  <= INIT_SHIFT_L;
    end else begin
      mode_q <= mode_n;
      dir_q  <= dir_n;
      led_q  <= led_n;
    end
  end

  // A mode change outranks a step arriving on the same cycle.
  always_comb begin
    mode_n = mode_q;
    dir_n  = dir_q;
    led_n  = led_q;
    if (mode_evt) begin
      mode_n = next_mode(mode_q);
      dir_n  = DIR_LEFT;
      led_n  = initial_pattern(next_mode(mode_q));
    end else if (step && run) begin
      case (mode_q)
        SHIFT_L: led_n = {led_q[LED_W-2:0], led_q[LED_W-1]};
        SHIFT_R: led_n = {led_q[0], led_q[LED_W-1:1]};
        BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            if (led_q == LED_MSB) begin
              dir_n = DIR_RIGHT;
              led_n = led_q >> 1;
            end else begin
              led_n = led_q << 1;
            end
          end else begin
            if (led_q == LED_LSB) begin
              dir_n = DIR_LEFT;
              led_n = led_q << 1;
            end else begin
              led_n = led_q >> 1;
            end
          end
        end
        default: led_n = ~led_q;
      endcase
    end
  end

  always_comb begin
    leds = led_q;
    mode = mode_q;
  end

endmodule
